// File: rtl/mem_stage_hs.sv
// Memory stage: branch resolution, store-data forwarding, req/ack data-memory
// access with bounded timeout, and the MEM/WB register.
module mem_stage_hs #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IMM_WIDTH  = 9,
    parameter int REG_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] alu_out_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [IMM_WIDTH-1:0]  imm_i,
    input  logic [REG_WIDTH-1:0]  write_reg_i,
    input  logic                  reg_write_i,
    input  logic                  branch_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  mov_i,
    input  logic                  fwd_sel_i,
    input  logic [DATA_WIDTH-1:0] result_w_i,
    input  logic                  stall_wb_i,
    input  logic                  dm_ack_i,
    input  logic [DATA_WIDTH-1:0] dm_rdata_i,
    output logic                  dm_req_o,
    output logic                  dm_we_o,
    output logic [ADDR_WIDTH-1:0] dm_addr_o,
    output logic [DATA_WIDTH-1:0] dm_wdata_o,
    output logic                  branch_taken_o,
    output logic [ADDR_WIDTH-1:0] branch_addr_o,
    output logic                  stall_mem_o,
    output logic                  dm_err_o,
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_o,
    output logic [DATA_WIDTH-1:0] wb_result_o,
    output logic [REG_WIDTH-1:0]  wb_reg_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  rd_q, rd_d;
    logic                  rw_q, rw_d;
    logic [REG_WIDTH-1:0]  reg_q, reg_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_WIDTH-1:0] cap_res_q, cap_res_d;
    logic                  cap_rw_q, cap_rw_d;
    logic                  err_q, err_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_rw_q, wb_rw_d;
    logic [DATA_WIDTH-1:0] wb_res_q, wb_res_d;
    logic [REG_WIDTH-1:0]  wb_reg_q, wb_reg_d;

    logic [DATA_WIDTH-1:0] op_s;
    logic [DATA_WIDTH-1:0] imm_data_s;
    logic [ADDR_WIDTH-1:0] imm_addr_s;
    logic [DATA_WIDTH-1:0] alu_res_s;
    logic                  mem_op_s;
    logic                  timeout_s;
    logic [DATA_WIDTH-1:0] fin_res_s;
    logic                  fin_rw_s;
    logic                  stall_s;

    assign op_s       = fwd_sel_i ? result_w_i : write_data_i;
    assign imm_data_s = DATA_WIDTH'($signed(imm_i));
    assign imm_addr_s = ADDR_WIDTH'($signed(imm_i));
    assign alu_res_s  = mov_i ? imm_data_s : alu_out_i;
    assign mem_op_s   = valid_i & (mem_read_i | mem_write_i);
    // Ack in the final counted cycle wins over the timeout.
    assign timeout_s  = (state_q == ST_ACCESS) & ~dm_ack_i & (cnt_q == CNT_LAST);
    assign fin_res_s  = timeout_s ? {DATA_WIDTH{1'b0}} : (rd_q ? dm_rdata_i : res_q);
    assign fin_rw_s   = timeout_s ? 1'b0 : rw_q;

    // Next-state, MEM/WB load and stall decision.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        reg_d      = reg_q;
        res_d      = res_q;
        cap_res_d  = cap_res_q;
        cap_rw_d   = cap_rw_q;
        err_d      = err_q;
        wb_valid_d = wb_valid_q;
        wb_rw_d    = wb_rw_q;
        wb_res_d   = wb_res_q;
        wb_reg_d   = wb_reg_q;
        stall_s    = stall_wb_i;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_s) begin
                    addr_d  = imm_addr_s;
                    wdata_d = op_s;
                    we_d    = mem_write_i;
                    rd_d    = mem_read_i;
                    rw_d    = reg_write_i;
                    reg_d   = write_reg_i;
                    res_d   = alu_res_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_ACCESS;
                    stall_s = 1'b1;
                    if (!stall_wb_i) begin
                        wb_valid_d = 1'b0;
                        wb_rw_d    = 1'b0;
                    end else begin
                        wb_valid_d = wb_valid_q;
                    end
                end else if (!stall_wb_i) begin
                    wb_valid_d = valid_i;
                    wb_rw_d    = valid_i & reg_write_i;
                    wb_res_d   = alu_res_s;
                    wb_reg_d   = write_reg_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (dm_ack_i || timeout_s) begin
                    err_d = err_q | timeout_s;
                    if (!stall_wb_i) begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = fin_rw_s;
                        wb_res_d   = fin_res_s;
                        wb_reg_d   = reg_q;
                        state_d    = ST_IDLE;
                    end else begin
                        cap_res_d = fin_res_s;
                        cap_rw_d  = fin_rw_s;
                        state_d   = ST_DONE;
                    end
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    stall_s = 1'b1;
                    if (!stall_wb_i) begin
                        wb_valid_d = 1'b0;
                        wb_rw_d    = 1'b0;
                    end else begin
                        wb_valid_d = wb_valid_q;
                    end
                end
            end
            ST_DONE: begin
                stall_s = 1'b1;
                if (!stall_wb_i) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = cap_rw_q;
                    wb_res_d   = cap_res_q;
                    wb_reg_d   = reg_q;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and MEM/WB registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= {DATA_WIDTH{1'b0}};
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            rw_q       <= 1'b0;
            reg_q      <= {REG_WIDTH{1'b0}};
            res_q      <= {DATA_WIDTH{1'b0}};
            cap_res_q  <= {DATA_WIDTH{1'b0}};
            cap_rw_q   <= 1'b0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_res_q   <= {DATA_WIDTH{1'b0}};
            wb_reg_q   <= {REG_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            reg_q      <= reg_d;
            res_q      <= res_d;
            cap_res_q  <= cap_res_d;
            cap_rw_q   <= cap_rw_d;
            err_q      <= err_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_res_q   <= wb_res_d;
            wb_reg_q   <= wb_reg_d;
        end
    end

    assign dm_req_o       = (state_q == ST_ACCESS);
    assign dm_we_o        = we_q & (state_q == ST_ACCESS);
    assign dm_addr_o      = addr_q;
    assign dm_wdata_o     = wdata_q;
    assign dm_err_o       = err_q;
    assign stall_mem_o    = stall_s;
    assign branch_taken_o = ~rst & (state_q == ST_IDLE) & valid_i & branch_i
                            & (op_s == {DATA_WIDTH{1'b0}});
    assign branch_addr_o  = pc_i + imm_addr_s;
    assign wb_valid_o     = wb_valid_q;
    assign wb_reg_write_o = wb_rw_q;
    assign wb_result_o    = wb_res_q;
    assign wb_reg_o       = wb_reg_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: expected MEM/WB entries are queued at issue
// and checked by an independent monitor; handshake/branch outputs checked inline.
module tb_mem_stage_hs;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int IW = 9;
    localparam int RW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i, reg_write_i, branch_i, mem_read_i, mem_write_i, mov_i;
    logic          fwd_sel_i, stall_wb_i, dm_ack_i;
    logic [AW-1:0] pc_i;
    logic [DW-1:0] alu_out_i, write_data_i, result_w_i, dm_rdata_i;
    logic [IW-1:0] imm_i;
    logic [RW-1:0] write_reg_i;
    logic          dm_req_o, dm_we_o, branch_taken_o, stall_mem_o, dm_err_o;
    logic          wb_valid_o, wb_reg_write_o;
    logic [AW-1:0] dm_addr_o, branch_addr_o;
    logic [DW-1:0] dm_wdata_o, wb_result_o;
    logic [RW-1:0] wb_reg_o;

    always #5 clk = ~clk;

    mem_stage_hs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMM_WIDTH(IW),
                   .REG_WIDTH(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .alu_out_i(alu_out_i),
        .write_data_i(write_data_i), .imm_i(imm_i), .write_reg_i(write_reg_i),
        .reg_write_i(reg_write_i), .branch_i(branch_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .mov_i(mov_i), .fwd_sel_i(fwd_sel_i),
        .result_w_i(result_w_i), .stall_wb_i(stall_wb_i), .dm_ack_i(dm_ack_i),
        .dm_rdata_i(dm_rdata_i), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
        .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .branch_taken_o(branch_taken_o),
        .branch_addr_o(branch_addr_o), .stall_mem_o(stall_mem_o), .dm_err_o(dm_err_o),
        .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o),
        .wb_result_o(wb_result_o), .wb_reg_o(wb_reg_o)
    );

    typedef struct packed {
        logic [DW-1:0] res;
        logic [RW-1:0] rg;
        logic          rw;
    } wb_t;

    wb_t  exp_q[$];
    wb_t  mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    logic load_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // MEM/WB monitor: an entry is new when the register was free at the previous edge.
    always @(negedge clk) begin
        if (wb_valid_o && load_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL wb_unexpected: got result %h reg %0d, expected no entry",
                         wb_result_o, wb_reg_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_result", {16'd0, wb_result_o}, {16'd0, mon_e.res});
                chk("wb_reg", {28'd0, wb_reg_o}, {28'd0, mon_e.rg});
                chk("wb_reg_write", {31'd0, wb_reg_write_o}, {31'd0, mon_e.rw});
            end
        end
        load_prev = !stall_wb_i && !rst;
    end

    task automatic clr();
        valid_i = 1'b0; reg_write_i = 1'b0; branch_i = 1'b0; mem_read_i = 1'b0;
        mem_write_i = 1'b0; mov_i = 1'b0; fwd_sel_i = 1'b0; stall_wb_i = 1'b0;
        dm_ack_i = 1'b0; pc_i = 8'h00; alu_out_i = 16'h0000; write_data_i = 16'h0000;
        result_w_i = 16'h0000; dm_rdata_i = 16'h0000; imm_i = 9'h000; write_reg_i = 4'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_req"}, {31'd0, dm_req_o}, 32'd0);
        chk({tag, "_we"}, {31'd0, dm_we_o}, 32'd0);
        chk({tag, "_addr"}, {24'd0, dm_addr_o}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, dm_wdata_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, dm_err_o}, 32'd0);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid_o}, 32'd0);
        chk({tag, "_wb_rw"}, {31'd0, wb_reg_write_o}, 32'd0);
        chk({tag, "_wb_result"}, {16'd0, wb_result_o}, 32'd0);
        chk({tag, "_wb_reg"}, {28'd0, wb_reg_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        clr();
        rst = 1'b1;
        tick();
        valid_i = 1'b1; branch_i = 1'b1;
        mid(); chk_idle_zero("rst");
        chk("rst_branch", {31'd0, branch_taken_o}, 32'd0);
        tick(); rst = 1'b0; clr();

        // ALU op, one-cycle latency
        valid_i = 1'b1; reg_write_i = 1'b1; alu_out_i = 16'h1234; write_reg_i = 4'd3;
        exp_q.push_back(wb_t'{16'h1234, 4'd3, 1'b1});
        mid(); chk("alu_stall", {31'd0, stall_mem_o}, 32'd0);
        tick(); clr();
        mid(); chk("alu_stall_after", {31'd0, stall_mem_o}, 32'd0);

        // mov: sign-extended immediate
        tick();
        valid_i = 1'b1; reg_write_i = 1'b1; mov_i = 1'b1; imm_i = 9'h1F0;
        alu_out_i = 16'h7777; write_reg_i = 4'd5;
        exp_q.push_back(wb_t'{16'hFFF0, 4'd5, 1'b1});
        tick(); clr();

        // load, ack three cycles after accept
        valid_i = 1'b1; mem_read_i = 1'b1; reg_write_i = 1'b1; imm_i = 9'h020; write_reg_i = 4'd7;
        exp_q.push_back(wb_t'{16'hBEEF, 4'd7, 1'b1});
        mid(); chk("ld_t0_stall", {31'd0, stall_mem_o}, 32'd1);
        chk("ld_t0_req", {31'd0, dm_req_o}, 32'd0);
        tick(); clr();
        mid(); chk("ld_t1_req", {31'd0, dm_req_o}, 32'd1);
        chk("ld_t1_addr", {24'd0, dm_addr_o}, 32'h20);
        chk("ld_t1_we", {31'd0, dm_we_o}, 32'd0);
        chk("ld_t1_stall", {31'd0, stall_mem_o}, 32'd1);
        tick();
        mid(); chk("ld_t2_stall", {31'd0, stall_mem_o}, 32'd1);
        tick();
        dm_ack_i = 1'b1; dm_rdata_i = 16'hBEEF;
        mid(); chk("ld_t3_stall", {31'd0, stall_mem_o}, 32'd0);
        tick(); clr();
        mid(); chk("ld_t4_req", {31'd0, dm_req_o}, 32'd0);
        tick();

        // load completing while MEM/WB is held two cycles
        valid_i = 1'b1; mem_read_i = 1'b1; reg_write_i = 1'b1; imm_i = 9'h030; write_reg_i = 4'd8;
        exp_q.push_back(wb_t'{16'hCAFE, 4'd8, 1'b1});
        tick(); clr();
        tick();
        dm_ack_i = 1'b1; dm_rdata_i = 16'hCAFE; stall_wb_i = 1'b1;
        mid(); chk("hold_ack_stall", {31'd0, stall_mem_o}, 32'd1);
        tick();
        dm_rdata_i = 16'h1111;
        mid(); chk("hold_done_stall", {31'd0, stall_mem_o}, 32'd1);
        chk("hold_done_req", {31'd0, dm_req_o}, 32'd0);
        tick();
        dm_ack_i = 1'b0; stall_wb_i = 1'b0;
        mid(); chk("hold_release_stall", {31'd0, stall_mem_o}, 32'd1);
        tick();
        mid(); chk("hold_after_stall", {31'd0, stall_mem_o}, 32'd0);
        tick();

        // forwarded store, one-cycle ack, then a back-to-back load
        valid_i = 1'b1; mem_write_i = 1'b1; fwd_sel_i = 1'b1; result_w_i = 16'h00A5;
        write_data_i = 16'hFFFF; imm_i = 9'h010; write_reg_i = 4'd2; alu_out_i = 16'h4444;
        exp_q.push_back(wb_t'{16'h4444, 4'd2, 1'b0});
        tick(); clr();
        dm_ack_i = 1'b1;
        mid(); chk("st_req", {31'd0, dm_req_o}, 32'd1);
        chk("st_we", {31'd0, dm_we_o}, 32'd1);
        chk("st_wdata", {16'd0, dm_wdata_o}, 32'h00A5);
        chk("st_addr", {24'd0, dm_addr_o}, 32'h10);
        chk("st_stall", {31'd0, stall_mem_o}, 32'd0);
        tick(); clr();
        valid_i = 1'b1; mem_read_i = 1'b1; reg_write_i = 1'b1; imm_i = 9'h040; write_reg_i = 4'd9;
        exp_q.push_back(wb_t'{16'h5A5A, 4'd9, 1'b1});
        mid(); chk("b2b_stall", {31'd0, stall_mem_o}, 32'd1);
        tick(); clr();
        dm_ack_i = 1'b1; dm_rdata_i = 16'h5A5A;
        mid(); chk("b2b_req", {31'd0, dm_req_o}, 32'd1);
        chk("b2b_addr", {24'd0, dm_addr_o}, 32'h40);
        chk("b2b_we", {31'd0, dm_we_o}, 32'd0);
        tick(); clr();
        mid(); chk("b2b_req_drop", {31'd0, dm_req_o}, 32'd0);
        tick();

        // branches
        valid_i = 1'b1; branch_i = 1'b1; pc_i = 8'h10; imm_i = 9'h1FE; write_data_i = 16'h0000;
        exp_q.push_back(wb_t'{16'h0000, 4'd0, 1'b0});
        mid(); chk("br_taken", {31'd0, branch_taken_o}, 32'd1);
        chk("br_addr", {24'd0, branch_addr_o}, 32'h0E);
        tick();
        write_data_i = 16'h0001;
        exp_q.push_back(wb_t'{16'h0000, 4'd0, 1'b0});
        mid(); chk("br_not_taken", {31'd0, branch_taken_o}, 32'd0);
        tick();
        fwd_sel_i = 1'b1; result_w_i = 16'h0000; write_data_i = 16'h0005;
        pc_i = 8'hF8; imm_i = 9'h010;
        exp_q.push_back(wb_t'{16'h0000, 4'd0, 1'b0});
        mid(); chk("br_fwd_taken", {31'd0, branch_taken_o}, 32'd1);
        chk("br_wrap_addr", {24'd0, branch_addr_o}, 32'h08);
        tick(); clr();

        // timeout: no ack
        valid_i = 1'b1; mem_read_i = 1'b1; reg_write_i = 1'b1; imm_i = 9'h050; write_reg_i = 4'd4;
        exp_q.push_back(wb_t'{16'h0000, 4'd4, 1'b0});
        mid(); chk("to_t0_stall", {31'd0, stall_mem_o}, 32'd1);
        tick(); clr();
        dm_rdata_i = 16'hDEAD;
        for (int i = 1; i < TO; i++) begin
            mid(); chk("to_wait_stall", {31'd0, stall_mem_o}, 32'd1);
            chk("to_wait_req", {31'd0, dm_req_o}, 32'd1);
            tick();
        end
        mid(); chk("to_last_stall", {31'd0, stall_mem_o}, 32'd0);
        chk("to_last_err", {31'd0, dm_err_o}, 32'd0);
        tick();
        mid(); chk("to_err_set", {31'd0, dm_err_o}, 32'd1);
        chk("to_req_drop", {31'd0, dm_req_o}, 32'd0);
        tick(); tick();
        mid(); chk("to_err_sticky", {31'd0, dm_err_o}, 32'd1);
        tick(); clr();

        // reset held two cycles mid-access, then a stray ack
        valid_i = 1'b1; mem_read_i = 1'b1; reg_write_i = 1'b1; imm_i = 9'h060; write_reg_i = 4'd6;
        tick(); clr();
        mid(); chk("rx_req_before", {31'd0, dm_req_o}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        mid(); chk("rx_req_in_rst", {31'd0, dm_req_o}, 32'd0);
        tick();
        rst = 1'b0;
        mid(); chk_idle_zero("rx");
        tick();
        dm_ack_i = 1'b1; dm_rdata_i = 16'h9999;
        mid(); chk("rx_stray_req", {31'd0, dm_req_o}, 32'd0);
        tick(); clr();
        mid(); chk_idle_zero("rx_after_ack");
        tick(); tick();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
